l2_arbiter: RTL and testbench

L2_ARBITER -- requirements
Module: l2_arbiter

---
 rtl/l2_arbiter.sv | 159 +++++++++++++++
 tb/tb_l2_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// Purpose: round-robin arbiter merging I-cache and D-cache line requests onto one L2 port.
// Latency: req pulse cycle 0 -> l2_req cycle 1 -> valid one cycle after the L2 ack.
// Backpressure: one pending slot per requester; l2_req is held until l2_ack, repeat reqs while pending are dropped.
// Optional build macro L2_ARB_STATS_EN adds the i_grants / d_grants counters.
module l2_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 512
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_add,
   output logic              i_valid,
   output logic [LINE_W-1:0] i_data,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_add,
   input  logic              d_we,
   input  logic [LINE_W-1:0] d_wdata,
   output logic              d_valid,
   output logic [LINE_W-1:0] d_data,
   output logic              l2_req,
   output logic [ADDR_W-1:0] l2_add,
   output logic              l2_we,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic              l2_ack,
   input  logic [LINE_W-1:0] l2_rdata,
   output logic              busy
`ifdef L2_ARB_STATS_EN
   ,
   output logic [31:0]       i_grants,
   output logic [31:0]       d_grants
`endif
);

   // One L2 command: everything that must stay stable while l2_req is high.
   typedef struct packed {
      logic [ADDR_W-1:0] add;
      logic              we;
      logic [LINE_W-1:0] wdata;
   } l2_cmd_t;

   typedef enum logic [1:0] {IDLE, GRANT, WAIT, DONE} state_t;

   state_t  state_q, state_d;
   logic    i_pend_vld, d_pend_vld;
   l2_cmd_t i_cmd_q, d_cmd_q;     // captured fields per requester
   l2_cmd_t cmd_q;                // fields of the transaction on the L2 port
   logic    win_d_q;              // current winner: 1 = D, 0 = I
   logic    last_d_q;             // last granted: 1 = D, so I wins the first tie

   l2_cmd_t i_cmd_in, d_cmd_in, i_cmd_eff, d_cmd_eff;
   logic    i_eff, d_eff, pick_d, grant_go, acked;
   logic    i_grant_clr, d_grant_clr;

   assign i_cmd_in = '{add: i_add, we: 1'b0, wdata: '0};
   assign d_cmd_in = '{add: d_add, we: d_we, wdata: d_wdata};

   // A req pulse arriving in IDLE takes part in arbitration in that same cycle.
   assign i_eff     = i_pend_vld | i_req;
   assign d_eff     = d_pend_vld | d_req;
   assign i_cmd_eff = i_pend_vld ? i_cmd_q : i_cmd_in;
   assign d_cmd_eff = d_pend_vld ? d_cmd_q : d_cmd_in;
   assign pick_d    = d_eff & (~i_eff | ~last_d_q);
   assign grant_go  = (state_q == IDLE) & (i_eff | d_eff);
   assign acked     = ((state_q == GRANT) | (state_q == WAIT)) & l2_ack;

   // The GRANT cycle retires the winner's pending slot; a pulse in that cycle re-arms it.
   assign i_grant_clr = (state_q == GRANT) & ~win_d_q;
   assign d_grant_clr = (state_q == GRANT) &  win_d_q;

   // State register.
   always_ff @(posedge clk) begin
      if (clear) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; acks outside GRANT/WAIT fall through unused.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_eff | d_eff) state_d = GRANT;
         GRANT:   state_d = l2_ack ? DONE : WAIT;
         WAIT:    if (l2_ack) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Per-requester pending flag and captured fields.
   always_ff @(posedge clk) begin
      if (clear) begin
         i_pend_vld <= 1'b0;
         d_pend_vld <= 1'b0;
         i_cmd_q    <= '0;
         d_cmd_q    <= '0;
      end else begin
         if (i_grant_clr) begin
            i_pend_vld <= i_req;
            if (i_req) i_cmd_q <= i_cmd_in;
         end else if (i_req & ~i_pend_vld) begin
            i_pend_vld <= 1'b1;
            i_cmd_q    <= i_cmd_in;
         end
         if (d_grant_clr) begin
            d_pend_vld <= d_req;
            if (d_req) d_cmd_q <= d_cmd_in;
         end else if (d_req & ~d_pend_vld) begin
            d_pend_vld <= 1'b1;
            d_cmd_q    <= d_cmd_in;
         end
      end
   end

   // Latch the winner's command on IDLE exit so a re-armed slot cannot disturb the L2 port.
   always_ff @(posedge clk) begin
      if (clear) begin
         cmd_q    <= '0;
         win_d_q  <= 1'b0;
         last_d_q <= 1'b1;
      end else if (grant_go) begin
         cmd_q    <= pick_d ? d_cmd_eff : i_cmd_eff;
         win_d_q  <= pick_d;
         last_d_q <= pick_d;
      end
   end

   // Capture the returned line for the winner; each output holds until its next completion.
   always_ff @(posedge clk) begin
      if (clear) begin
         i_data <= '0;
         d_data <= '0;
      end else if (acked) begin
         if (win_d_q) d_data <= l2_rdata;
         else         i_data <= l2_rdata;
      end
   end

`ifdef L2_ARB_STATS_EN
   // Grant counters, bumped on each IDLE -> GRANT entry and wrapping naturally.
   always_ff @(posedge clk) begin
      if (clear) begin
         i_grants <= '0;
         d_grants <= '0;
      end else if (grant_go) begin
         if (pick_d) d_grants <= d_grants + 32'd1;
         else        i_grants <= i_grants + 32'd1;
      end
   end
`endif

   assign l2_req   = (state_q == GRANT) | (state_q == WAIT);
   assign l2_add   = cmd_q.add;
   assign l2_we    = cmd_q.we;
   assign l2_wdata = cmd_q.wdata;
   assign busy     = (state_q != IDLE);
   assign i_valid  = (state_q == DONE) & ~win_d_q;
   assign d_valid  = (state_q == DONE) &  win_d_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: directed requests, an L2 responder model and a valid monitor.
// Latency: responder acks a configurable number of cycles after each l2_req rise.
// Backpressure: responder holds off acks when disabled, to strand a transaction for the clear case.
module tb_l2_arbiter;
   localparam int AW = 32;
   localparam int LW = 512;

   logic          clk = 1'b0;
   logic          clear, i_req, d_req, d_we;
   logic [AW-1:0] i_add, d_add;
   logic [LW-1:0] d_wdata;
   logic          i_valid, d_valid, l2_req, l2_we, busy;
   logic [LW-1:0] i_data, d_data, l2_wdata, l2_rdata;
   logic [AW-1:0] l2_add;
   logic          rsp_ack, frc_ack, l2_ack;
`ifdef L2_ARB_STATS_EN
   logic [31:0]   i_grants, d_grants;
`endif

   assign l2_ack = rsp_ack | frc_ack;

   always #5 clk = ~clk;

   l2_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
      .clk(clk), .clear(clear),
      .i_req(i_req), .i_add(i_add), .i_valid(i_valid), .i_data(i_data),
      .d_req(d_req), .d_add(d_add), .d_we(d_we), .d_wdata(d_wdata),
      .d_valid(d_valid), .d_data(d_data),
      .l2_req(l2_req), .l2_add(l2_add), .l2_we(l2_we), .l2_wdata(l2_wdata),
      .l2_ack(l2_ack), .l2_rdata(l2_rdata), .busy(busy)
`ifdef L2_ARB_STATS_EN
      , .i_grants(i_grants), .d_grants(d_grants)
`endif
   );

   typedef struct {
      logic          is_d;
      logic [LW-1:0] dat;
   } vexp_t;
   typedef struct {
      logic [AW-1:0] add;
      logic          we;
      logic [LW-1:0] wdata;
   } cexp_t;

   vexp_t vq[$];
   cexp_t cq[$];
   int    errors = 0;
   int    checks = 0;
   int    ack_dly = 0;
   bit    ack_en = 1'b1;
   bit    chk_gap = 1'b0;
   bit    mon_en = 1'b0;
   logic [LW-1:0] pat_b;

   // Next-level memory contents: a line derived from its address.
   function automatic logic [LW-1:0] mem(input logic [AW-1:0] a);
      return {16{a ^ 32'hC0DE_0000}};
   endfunction

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic exp_rd(input logic is_d, input logic [AW-1:0] a);
      cq.push_back('{add: a, we: 1'b0, wdata: {LW{1'b0}}});
      vq.push_back('{is_d: is_d, dat: mem(a)});
   endtask

   task automatic exp_wb(input logic [AW-1:0] a, input logic [LW-1:0] wd);
      cq.push_back('{add: a, we: 1'b1, wdata: wd});
      vq.push_back('{is_d: 1'b1, dat: mem(a)});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_i(input logic [AW-1:0] a);
      i_req = 1'b1; i_add = a;
      tick();
      i_req = 1'b0; i_add = 32'hDEAD_DEAD;
   endtask

   task automatic pulse_d(input logic [AW-1:0] a, input logic we, input logic [LW-1:0] wd);
      d_req = 1'b1; d_add = a; d_we = we; d_wdata = wd;
      tick();
      d_req = 1'b0; d_add = 32'hBEEF_BEEF; d_we = ~we; d_wdata = ~wd;
   endtask

   task automatic pulse_both(input logic [AW-1:0] ia, input logic [AW-1:0] da);
      i_req = 1'b1; i_add = ia;
      d_req = 1'b1; d_add = da; d_we = 1'b0; d_wdata = '0;
      tick();
      i_req = 1'b0; d_req = 1'b0; i_add = 32'hDEAD_DEAD; d_add = 32'hBEEF_BEEF;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (n < 300) begin
         tick();
         if (!busy && vq.size() == 0 && cq.size() == 0) break;
         n++;
      end
      check("drain_timeout", LW'(n < 300), LW'(1));
   endtask

   // L2 responder: checks issued fields against the queue, holds them stable, acks after ack_dly.
   cexp_t cur;
   logic  prev_req = 1'b0;
   int    cnt = 0;
   int    idle_cnt = 0;
   always @(negedge clk) begin
      rsp_ack = 1'b0;
      if (clear) begin
         prev_req = 1'b0;
         cnt      = 0;
         idle_cnt = 0;
      end else begin
         if (l2_req && !prev_req) begin
            // busy-low cycles since the last burst, i.e. IDLE cycles (l2_req is also low in DONE)
            if (chk_gap) check("idle_gap", LW'(idle_cnt), LW'(1));
            if (cq.size() == 0) begin
               checks++; errors++;
               $display("FAIL l2_unexpected: got request add=%0h expected none", l2_add);
               cur = '{add: l2_add, we: l2_we, wdata: l2_wdata};
            end else begin
               cur = cq.pop_front();
               check("l2_add", LW'(l2_add), LW'(cur.add));
               check("l2_we", LW'(l2_we), LW'(cur.we));
               check("l2_wdata", l2_wdata, cur.wdata);
            end
            cnt = 0;
         end else if (l2_req) begin
            check("l2_add_stable", LW'(l2_add), LW'(cur.add));
            check("l2_wdata_stable", l2_wdata, cur.wdata);
         end
         if (l2_req) begin
            idle_cnt = 0;
            if (ack_en && cnt == ack_dly) begin
               rsp_ack  = 1'b1;
               l2_rdata = mem(l2_add);
            end
            cnt++;
         end else if (!busy) begin
            idle_cnt++;
         end
         prev_req = l2_req;
      end
   end

   // Completion monitor: pops the scoreboard on each valid and checks held data otherwise.
   logic [LW-1:0] last_i = '0;
   logic [LW-1:0] last_d = '0;
   vexp_t e;
   always @(negedge clk) begin
      if (mon_en) begin
         if (i_valid || d_valid) begin
            check("valid_exclusive", LW'(i_valid & d_valid), LW'(0));
            if (vq.size() == 0) begin
               checks++; errors++;
               $display("FAIL valid_unexpected: got i_valid=%0d d_valid=%0d expected none", i_valid, d_valid);
            end else begin
               e = vq.pop_front();
               check("valid_who", LW'(d_valid), LW'(e.is_d));
               check("valid_data", d_valid ? d_data : i_data, e.dat);
            end
         end
         if (!i_valid) check("i_data_hold", i_data, last_i);
         else          last_i = i_data;
         if (!d_valid) check("d_data_hold", d_data, last_d);
         else          last_d = d_data;
         if (clear) begin
            last_i = '0;
            last_d = '0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      pat_b   = {8{64'h0123_4567_89AB_CDEF}};
      clear   = 1'b1;
      i_req   = 1'b0; i_add = '0;
      d_req   = 1'b0; d_add = '0; d_we = 1'b0; d_wdata = '0;
      frc_ack = 1'b0; rsp_ack = 1'b0; l2_rdata = '0;
      repeat (3) tick();
      clear = 1'b0;

      // reset state
      check("rst_l2_req", LW'(l2_req), LW'(0));
      check("rst_busy", LW'(busy), LW'(0));
      check("rst_i_valid", LW'(i_valid), LW'(0));
      check("rst_d_valid", LW'(d_valid), LW'(0));
      check("rst_i_data", i_data, LW'(0));
      check("rst_d_data", d_data, LW'(0));
      check("rst_l2_add", LW'(l2_add), LW'(0));
      check("rst_l2_we", LW'(l2_we), LW'(0));
      check("rst_l2_wdata", l2_wdata, LW'(0));
      mon_en = 1'b1;

      // simultaneous requests right after reset: I wins the first tie, then D
      ack_dly = 0;
      exp_rd(1'b0, 32'h0000_3000);
      exp_rd(1'b1, 32'h0000_4000);
      pulse_both(32'h0000_3000, 32'h0000_4000);
      wait_idle();

      // single I read acked three cycles after l2_req
      ack_dly = 3;
      exp_rd(1'b0, 32'h0000_1000);
      pulse_i(32'h0000_1000);
      wait_idle();

      // I in flight, then I and D in the same cycle: D (not last granted) first, then I
      ack_dly = 2;
      exp_rd(1'b0, 32'h0000_5000);
      exp_rd(1'b1, 32'h0000_6000);
      exp_rd(1'b0, 32'h0000_7000);
      pulse_i(32'h0000_5000);
      tick();
      chk_gap = 1'b1;
      pulse_both(32'h0000_7000, 32'h0000_6000);
      wait_idle();
      chk_gap = 1'b0;

      // D writeback
      ack_dly = 1;
      exp_wb(32'h0000_2040, pat_b);
      pulse_d(32'h0000_2040, 1'b1, pat_b);
      wait_idle();

      // duplicate I request while I is pending behind a D read: original address kept
      ack_dly = 4;
      exp_rd(1'b1, 32'h0000_8000);
      exp_rd(1'b0, 32'h0000_9000);
      pulse_d(32'h0000_8000, 1'b0, '0);
      tick();
      pulse_i(32'h0000_9000);
      pulse_i(32'h0000_A000);
      wait_idle();

      // clear in WAIT, then a stray late ack
      ack_en = 1'b0;
      cq.push_back('{add: 32'h0000_B000, we: 1'b0, wdata: {LW{1'b0}}});
      pulse_i(32'h0000_B000);
      tick();
      check("clr_pre_busy", LW'(busy), LW'(1));
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clr_l2_req", LW'(l2_req), LW'(0));
      check("clr_busy", LW'(busy), LW'(0));
      check("clr_i_valid", LW'(i_valid), LW'(0));
      check("clr_i_data", i_data, LW'(0));
      check("clr_d_data", d_data, LW'(0));
      check("clr_l2_add", LW'(l2_add), LW'(0));
`ifdef L2_ARB_STATS_EN
      check("clr_i_grants", LW'(i_grants), LW'(0));
      check("clr_d_grants", LW'(d_grants), LW'(0));
`endif
      frc_ack = 1'b1;
      tick();
      frc_ack = 1'b0;
      check("late_ack_busy", LW'(busy), LW'(0));
      check("late_ack_l2_req", LW'(l2_req), LW'(0));
      repeat (3) tick();
      check("late_ack_idle", LW'(busy), LW'(0));
      ack_en = 1'b1;

      // three I and two D completions after the clear
      ack_dly = 0;
      for (int k = 0; k < 5; k++) begin
         if (k % 2 == 0) begin
            exp_rd(1'b0, 32'h0001_0000 + 32'(k));
            pulse_i(32'h0001_0000 + 32'(k));
         end else begin
            exp_rd(1'b1, 32'h0002_0000 + 32'(k));
            pulse_d(32'h0002_0000 + 32'(k), 1'b0, '0);
         end
         wait_idle();
      end
`ifdef L2_ARB_STATS_EN
      check("i_grants", LW'(i_grants), LW'(3));
      check("d_grants", LW'(d_grants), LW'(2));
`endif

      repeat (3) tick();
      check("queues_empty", LW'(vq.size() + cq.size()), LW'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
